// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART byte width and TX FIFO handshake state encoding
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - byte storage for the TX FIFO, synchronous write, combinational read
module uart_fifo_mem #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte queue feeding the uart tx_valid/tx_busy handshake
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
import uart_pkg::*;

module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = UART_DATA_W
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  wr_valid,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ready,
  output logic                  tx_valid,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int AW = DEPTH_LOG2;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wptr, rptr;
  logic [DATA_W-1:0] head;
  logic              do_wr, do_pop, tx_valid_next;
  tx_state_t         state, state_next;

  // Extra wrap bit distinguishes full from empty when the low bits match.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level    = wptr - rptr;
  assign wr_ready = !full;
  assign do_wr    = wr_valid && !full;
  assign do_pop   = (state == IDLE) && !empty && !tx_busy;

  uart_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wptr    <= '0;
      rptr    <= '0;
      tx_data <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PTR_ONE;
      if (do_pop) begin
        rptr    <= rptr + PTR_ONE;
        tx_data <= head;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_next;
      tx_valid <= tx_valid_next;
    end
  end

  // tx_valid is held through SEND until busy is seen while it is already asserted.
  always_comb begin
    state_next    = state;
    tx_valid_next = 1'b0;
    case (state)
      IDLE: if (do_pop) state_next = SEND;
      SEND: begin
        if (tx_valid && tx_busy) state_next = DONE;
        else                     tx_valid_next = 1'b1;
      end
      DONE: if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                 ovf <= 1'b0;
    else if (wr_valid && full) ovf <= 1'b1;
    else if (ovf_clr)          ovf <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a tx_busy model
import uart_pkg::*;

module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, tx_valid, empty, full, ovf;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [4:0] level;
  logic       ovf_clr = 1'b0;
  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
  logic       auto_en = 1'b1;
  logic       prev_v = 1'b0;

  int total = 0;
  int bad = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic       wv;
    logic [7:0] d;
    logic       clr;
    logic [4:0] lvl;
    logic       fl;
    logic       ov;
  } vec_t;
  vec_t tbl[24];

  assign tx_busy = force_busy | model_busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(4), .DATA_W(UART_DATA_W)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  // Transmitter stand-in: busy rises 1-3 clk after tx_valid and lasts 20 clk.
  always begin
    @(posedge clk);
    #1;
    if (auto_en && tx_valid && !model_busy) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #2 model_busy = 1'b1;
      repeat (20) @(posedge clk);
      #2 model_busy = 1'b0;
    end
  end

  // Every rising tx_valid is one byte handed to the transmitter.
  always begin
    @(posedge clk);
    #1;
    if (tx_valid && !prev_v) got.push_back(tx_data);
    prev_v = tx_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    exp_q.push_back(b);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int q = 0;
    int n = 0;
    while (q < 3 && n < 2000) begin
      step();
      n++;
      if (empty && !tx_valid && !tx_busy) q++;
      else q = 0;
    end
    chk({nm, "_drain"}, 32'(q >= 3), 1);
    chk({nm, "_level0"}, 32'(level), 0);
  endtask

  task automatic cmp_order(input string nm);
    chk({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk({nm, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 20; i++)
      tbl[i] = '{1'b1, 8'(8'h40 + i), 1'b0, 5'((i < 16) ? i + 1 : 16), (i >= 15), OVF_EN && (i >= 16)};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, OVF_EN};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0};
    tbl[22] = '{1'b1, 8'h77, 1'b1, 5'd16, 1'b1, OVF_EN};
    tbl[23] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0};

    // Reset values
    step();
    step();
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rstb = 1'b1;
    step();

    // Single byte latency and hold-until-busy
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    step();
    wr_valid = 1'b0;
    chk("t1_n_valid", 32'(tx_valid), 0);
    chk("t1_n_level", 32'(level), 1);
    step();
    chk("t1_pop_valid", 32'(tx_valid), 0);
    chk("t1_pop_level", 32'(level), 0);
    step();
    chk("t1_valid", 32'(tx_valid), 1);
    chk("t1_data", 32'(tx_data), 32'hA5);
    for (int k = 0; k < 8 && !tx_busy; k++) begin
      step();
      if (!tx_busy) chk("t1_hold", 32'(tx_valid), 1);
    end
    chk("t1_busy_seen", 32'(tx_busy), 1);
    chk("t1_valid_drop", 32'(tx_valid), 0);
    chk("t1_data_stable", 32'(tx_data), 32'hA5);
    drain("t1");
    cmp_order("t1");

    // Fill past capacity with the transmitter stalled; overflow flag handling
    force_busy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      wr_valid = tbl[i].wv;
      wr_data  = tbl[i].d;
      ovf_clr  = tbl[i].clr;
      step();
      chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
      chk("tbl_full", 32'(full), 32'(tbl[i].fl));
      chk("tbl_wr_ready", 32'(wr_ready), 32'(!tbl[i].fl));
      chk("tbl_ovf", 32'(ovf), 32'(tbl[i].ov));
      chk("tbl_tx_valid", 32'(tx_valid), 0);
    end
    wr_valid = 1'b0;
    ovf_clr  = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
    force_busy = 1'b0;
    drain("t3");
    cmp_order("t3");

    // Same-cycle write and pop at level 5
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h10 + i));
    chk("t4_level5", 32'(level), 5);
    force_busy = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h15;
    exp_q.push_back(8'h15);
    step();
    wr_valid = 1'b0;
    chk("t4_level_kept", 32'(level), 5);
    chk("t4_popped", 32'(tx_data), 32'h10);
    drain("t4");
    cmp_order("t4");

    // Busy held high in IDLE blocks issue
    force_busy = 1'b1;
    write_byte(8'h61);
    write_byte(8'h62);
    begin
      int seen = 0;
      for (int k = 0; k < 50; k++) begin
        step();
        if (tx_valid) seen++;
      end
      chk("t6_no_issue", seen, 0);
    end
    chk("t6_level", 32'(level), 2);
    force_busy = 1'b0;
    step();
    chk("t6_pop_valid", 32'(tx_valid), 0);
    chk("t6_pop_level", 32'(level), 1);
    step();
    chk("t6_valid", 32'(tx_valid), 1);
    chk("t6_data", 32'(tx_data), 32'h61);
    drain("t6");
    cmp_order("t6");

    // Asynchronous reset during SEND with 3 bytes queued
    auto_en = 1'b0;
    for (int i = 0; i < 4; i++) write_byte(8'(8'h20 + i));
    chk("t5_send_valid", 32'(tx_valid), 1);
    chk("t5_send_level", 32'(level), 3);
    #2 rstb = 1'b0;
    #1;
    chk("t5_async_valid", 32'(tx_valid), 0);
    chk("t5_async_level", 32'(level), 0);
    chk("t5_async_empty", 32'(empty), 1);
    step();
    rstb = 1'b0;
    step();
    rstb = 1'b1;
    auto_en = 1'b1;
    got.delete();
    exp_q.delete();
    step();
    write_byte(8'h3C);
    drain("t5");
    cmp_order("t5");

    // Random writes never exceeding capacity; order through pointer wrap
    for (int c = 0; c < 1200; c++) begin
      if ((exp_q.size() - got.size()) < 15 && $urandom_range(0, 3) == 0) begin
        wr_valid = 1'b1;
        wr_data  = 8'($urandom);
        exp_q.push_back(wr_data);
      end else begin
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
      end
      step();
    end
    wr_valid = 1'b0;
    chk("rnd_enough", 32'(exp_q.size() >= 40), 1);
    chk("rnd_ovf", 32'(ovf), 0);
    drain("rnd");
    cmp_order("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
